// File: rtl/avl_mem_responder.sv
// Avalon-MM memory responder: stand-in for the DDR3 controller local interface, backed by on-chip 64-bit RAM.
// Optional AVL_MEM_RANDOM_STALL_EN adds LFSR-driven avl_ready stalls in IDLE and WRITE_BURST.
module avl_mem_responder #(
  parameter int ADDR_BITS    = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 avl_ready,
  input  logic                 avl_burstbegin,
  input  logic [ADDR_BITS-1:0] avl_addr,
  input  logic                 avl_read_req,
  input  logic                 avl_write_req,
  input  logic [6:0]           avl_size,
  input  logic [63:0]          avl_wdata,
  input  logic [7:0]           avl_be,
  output logic [63:0]          avl_rdata,
  output logic                 avl_rdata_valid
);

  typedef enum logic [1:0] {IDLE, WRITE_BURST, READ_ISSUE} state_t;

  state_t                 state, state_n;
  logic [6:0]             cnt, cnt_n;
  logic [ADDR_BITS-1:0]   addr_q, addr_n;
  logic [ADDR_BITS-1:0]   waddr, raddr;
  logic                   we, issue, stall, live;
  logic [63:0]            mem [0:(1<<ADDR_BITS)-1];

  logic [READ_LATENCY:1]           vld_pipe;
  logic [READ_LATENCY:1][63:0]     dat_pipe;

  // burstbegin is informational; the FSM keys off size alone
  logic unused_burstbegin;
  assign unused_burstbegin = avl_burstbegin;

`ifdef AVL_MEM_RANDOM_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr <= 16'hACE1;
    else          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // live keeps avl_ready low while reset is held
  assign avl_ready = live && (state != READ_ISSUE) && !stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      live   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      addr_q <= addr_n;
      live   <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr_q;
    we      = 1'b0;
    issue   = 1'b0;
    waddr   = avl_addr;
    raddr   = avl_addr;
    case (state)
      IDLE: begin
        // write wins if both requests are raised together
        if (avl_ready && avl_write_req) begin
          we = 1'b1;
          if (avl_size > 7'd1) begin
            state_n = WRITE_BURST;
            cnt_n   = avl_size - 7'd1;
            addr_n  = avl_addr + ADDR_BITS'(1);
          end
        end else if (avl_ready && avl_read_req) begin
          issue = 1'b1;
          if (avl_size > 7'd1) begin
            state_n = READ_ISSUE;
            cnt_n   = avl_size - 7'd1;
            addr_n  = avl_addr + ADDR_BITS'(1);
          end
        end
      end
      WRITE_BURST: begin
        if (avl_ready && avl_write_req) begin
          we     = 1'b1;
          waddr  = addr_q;
          addr_n = addr_q + ADDR_BITS'(1);
          cnt_n  = cnt - 7'd1;
          if (cnt == 7'd1) state_n = IDLE;
        end
      end
      READ_ISSUE: begin
        issue  = 1'b1;
        raddr  = addr_q;
        addr_n = addr_q + ADDR_BITS'(1);
        cnt_n  = cnt - 7'd1;
        if (cnt == 7'd1) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 8; b++)
        if (avl_be[b]) mem[waddr][8*b +: 8] <= avl_wdata[8*b +: 8];
    end
  end

  // stage data only advances with a valid beat, so avl_rdata holds between beats
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= issue;
      if (issue) dat_pipe[1] <= mem[raddr];
      for (int s = 2; s <= READ_LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign avl_rdata       = dat_pipe[READ_LATENCY];
  assign avl_rdata_valid = vld_pipe[READ_LATENCY];

endmodule

// File: tb/tb_avl_mem_responder.sv
// Directed bench for avl_mem_responder: writes, partial writes, wrapping bursts, back-to-back reads, reset mid-burst.
module tb_avl_mem_responder;
  localparam int AB = 10;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          avl_ready;
  logic          avl_burstbegin;
  logic [AB-1:0] avl_addr;
  logic          avl_read_req;
  logic          avl_write_req;
  logic [6:0]    avl_size;
  logic [63:0]   avl_wdata;
  logic [7:0]    avl_be;
  logic [63:0]   avl_rdata;
  logic          avl_rdata_valid;

  avl_mem_responder #(.ADDR_BITS(AB), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset_n(reset_n), .avl_ready(avl_ready), .avl_burstbegin(avl_burstbegin),
    .avl_addr(avl_addr), .avl_read_req(avl_read_req), .avl_write_req(avl_write_req),
    .avl_size(avl_size), .avl_wdata(avl_wdata), .avl_be(avl_be),
    .avl_rdata(avl_rdata), .avl_rdata_valid(avl_rdata_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] bq_d[$];
  int          bq_c[$];
  always @(negedge clk)
    if (reset_n && avl_rdata_valid) begin
      bq_d.push_back(avl_rdata);
      bq_c.push_back(cyc);
    end

  int checks = 0;
  int fails  = 0;

  task automatic handshake(output int c);
    bit ok = 1'b0;
    bit rdy;
    c = -1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      rdy = avl_ready;
      c = cyc;
      @(posedge clk); #1;
      ok = rdy;
    end
    if (!ok) begin
      checks++; fails++;
      $display("FAIL handshake: avl_ready never high within 64 cycles");
    end
  endtask

  task automatic wr_beat(input logic [AB-1:0] a, input logic [63:0] d, input logic [7:0] be,
                         input logic [6:0] sz);
    int c;
    avl_addr = a; avl_wdata = d; avl_be = be; avl_size = sz;
    avl_write_req = 1'b1; avl_burstbegin = 1'b1;
    handshake(c);
    avl_write_req = 1'b0; avl_burstbegin = 1'b0;
  endtask

  task automatic rd(input logic [AB-1:0] a, input logic [6:0] sz, output int c);
    avl_addr = a; avl_size = sz; avl_read_req = 1'b1;
    handshake(c);
    avl_read_req = 1'b0;
  endtask

  task automatic clear_q();
    bq_d.delete();
    bq_c.delete();
  endtask

  task automatic wait_ready(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clk);
      seen = avl_ready;
    end
    checks++;
    if (seen !== 1'b1) begin fails++; $display("FAIL %s: avl_ready got 0 exp 1", nm); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; avl_burstbegin = 1'b0; avl_addr = '0; avl_read_req = 1'b0;
    avl_write_req = 1'b0; avl_size = '0; avl_wdata = '0; avl_be = '0;
    repeat (3) @(posedge clk); #1;
    checks++; if (avl_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b exp 0", avl_ready); end
    checks++; if (avl_rdata_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", avl_rdata_valid); end
    checks++; if (avl_rdata !== 64'h0) begin fails++; $display("FAIL reset_rdata got %h exp 0", avl_rdata); end
    reset_n = 1'b1;
    wait_ready("reset_release_ready");
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int c;
    wr_beat(10'h010, 64'h1122334455667788, 8'hFF, 7'd1);
    clear_q();
    rd(10'h010, 7'd1, c);
    repeat (8) @(posedge clk); #1;
    checks++; if (bq_d.size() !== 1) begin fails++; $display("FAIL single_count got %0d exp 1", bq_d.size()); end
    if (bq_d.size() > 0) begin
      checks++; if (bq_c[0] !== c + RL) begin fails++; $display("FAIL single_cycle got %0d exp %0d", bq_c[0], c + RL); end
      checks++; if (bq_d[0] !== 64'h1122334455667788) begin fails++; $display("FAIL single_data got %h exp 1122334455667788", bq_d[0]); end
    end
    // rdata holds its last value after the beat
    checks++; if (avl_rdata !== 64'h1122334455667788) begin fails++; $display("FAIL single_hold got %h exp 1122334455667788", avl_rdata); end
  endtask

  task automatic test_partial();
    int c;
    wr_beat(10'h010, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 7'd1);
    clear_q();
    rd(10'h010, 7'd0, c);
    repeat (8) @(posedge clk); #1;
    checks++; if (bq_d.size() !== 1) begin fails++; $display("FAIL partial_count got %0d exp 1", bq_d.size()); end
    if (bq_d.size() > 0) begin
      checks++; if (bq_d[0] !== 64'h11223344_BBBBBBBB) begin fails++; $display("FAIL partial_data got %h exp 11223344bbbbbbbb", bq_d[0]); end
    end
  endtask

  task automatic test_write_burst();
    wr_beat(10'h3FE, 64'd1, 8'hFF, 7'd4);
    wr_beat(10'h3FE, 64'd2, 8'hFF, 7'd4);
    @(posedge clk); #1;
    wr_beat(10'h3FE, 64'd3, 8'hFF, 7'd4);
    wr_beat(10'h3FE, 64'd4, 8'hFF, 7'd4);
  endtask

  task automatic test_read_burst();
    int c;
    int low = 0;
    clear_q();
    rd(10'h3FE, 7'd4, c);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (avl_ready === 1'b0) low++;
    end
    checks++; if (low !== 3) begin fails++; $display("FAIL burst_ready_low got %0d exp 3", low); end
`ifndef AVL_MEM_RANDOM_STALL_EN
    @(negedge clk);
    checks++; if (avl_ready !== 1'b1) begin fails++; $display("FAIL burst_ready_back got %b exp 1", avl_ready); end
`endif
    repeat (10) @(posedge clk); #1;
    checks++; if (bq_d.size() !== 4) begin fails++; $display("FAIL burst_count got %0d exp 4", bq_d.size()); end
    for (int k = 0; k < 4 && k < bq_d.size(); k++) begin
      checks++;
      if (bq_d[k] !== 64'(k + 1) || bq_c[k] !== c + RL + k) begin
        fails++;
        $display("FAIL burst_beat%0d got %0d@%0d exp %0d@%0d", k, bq_d[k], bq_c[k], k + 1, c + RL + k);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c0, c1;
    clear_q();
    rd(10'h3FE, 7'd2, c0);
    rd(10'h000, 7'd2, c1);
    repeat (10) @(posedge clk); #1;
    checks++; if (bq_d.size() !== 4) begin fails++; $display("FAIL b2b_count got %0d exp 4", bq_d.size()); end
    for (int k = 0; k < 4 && k < bq_d.size(); k++) begin
      checks++;
      if (bq_d[k] !== 64'(k + 1)) begin fails++; $display("FAIL b2b_data%0d got %0d exp %0d", k, bq_d[k], k + 1); end
    end
`ifndef AVL_MEM_RANDOM_STALL_EN
    if (bq_c.size() == 4) begin
      checks++;
      if (bq_c[3] !== c0 + RL + 3) begin fails++; $display("FAIL b2b_contig got last@%0d exp %0d", bq_c[3], c0 + RL + 3); end
    end
`endif
  endtask

  task automatic test_rw_conflict();
    int c;
    clear_q();
    avl_read_req = 1'b1;
    wr_beat(10'h020, 64'hDEADBEEF_CAFEF00D, 8'hFF, 7'd1);
    avl_read_req = 1'b0;
    repeat (6) @(posedge clk); #1;
    checks++; if (bq_d.size() !== 0) begin fails++; $display("FAIL conflict_read_ignored got %0d beats exp 0", bq_d.size()); end
    rd(10'h020, 7'd1, c);
    repeat (6) @(posedge clk); #1;
    checks++;
    if (bq_d.size() !== 1 || bq_d[0] !== 64'hDEADBEEF_CAFEF00D) begin
      fails++; $display("FAIL conflict_write_won got %0d beats exp 1 beat deadbeefcafef00d", bq_d.size());
    end
  endtask

  task automatic test_reset_mid();
    int c;
    clear_q();
    rd(10'h3FE, 7'd4, c);
    @(posedge clk); #1;
    checks++; if (avl_rdata_valid !== 1'b1) begin fails++; $display("FAIL mid_valid_before got %b exp 1", avl_rdata_valid); end
    reset_n = 1'b0;
    #1;
    checks++; if (avl_rdata_valid !== 1'b0) begin fails++; $display("FAIL mid_valid_drop got %b exp 0", avl_rdata_valid); end
    checks++; if (avl_rdata !== 64'h0) begin fails++; $display("FAIL mid_rdata_clear got %h exp 0", avl_rdata); end
    checks++; if (avl_ready !== 1'b0) begin fails++; $display("FAIL mid_ready_low got %b exp 0", avl_ready); end
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    clear_q();
    wait_ready("mid_ready_after");
    repeat (8) @(posedge clk); #1;
    checks++; if (bq_d.size() !== 0) begin fails++; $display("FAIL mid_stale_beats got %0d exp 0", bq_d.size()); end
    rd(10'h010, 7'd1, c);
    repeat (6) @(posedge clk); #1;
    checks++;
    if (bq_d.size() !== 1 || bq_d[0] !== 64'h11223344_BBBBBBBB) begin
      fails++; $display("FAIL mid_ram_kept got %0d beats exp 1 beat 11223344bbbbbbbb", bq_d.size());
    end
  endtask

  task automatic test_stall();
    int low = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (avl_ready === 1'b0) low++;
    end
    checks++;
`ifdef AVL_MEM_RANDOM_STALL_EN
    if (low == 0) begin fails++; $display("FAIL stall_seen got %0d low cycles exp >0", low); end
`else
    if (low !== 0) begin fails++; $display("FAIL idle_ready got %0d low cycles exp 0", low); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_partial();
    test_write_burst();
    test_read_burst();
    test_back_to_back();
    test_rw_conflict();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
